div32x16_seq: RTL and testbench

//  Sequential unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient + remainder.

---
 rtl/div32x16_seq.sv | 130 +++++++++++++
 tb/tb_div32x16_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div32x16_seq.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// One quotient bit per enabled clock, start/busy/done handshake, results held until next start.
module div32x16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Next-state and datapath: accept in IDLE, one restoring step per RUN cycle, publish on RUN exit.
  // Divide-by-zero/overflow preload the saturated result with the counter already at LAST, so they
  // take the same single RUN finishing cycle as a normal divide's final edge.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    shifted = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    case (state_q)
      IDLE: begin
        if (enable && start) begin
          dvs_d = divisor;
          dz_d  = (divisor == '0);
          ov_d  = (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
          if (dz_d || ov_d) begin
            rem_d = {1'b0, dividend[WIDTH-1:0]};
            q_d   = '1;
            cnt_d = LAST;
          end else begin
            rem_d = {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_d   = dividend[WIDTH-1:0];
            cnt_d = '0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        if (enable) begin
          if (cnt_q == LAST) begin
            quot_d  = q_q;
            rmd_d   = rem_q[WIDTH-1:0];
            state_d = DONE;
          end else begin
            if (!trial[WIDTH+1]) begin
              rem_d = trial[WIDTH:0];
              q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = shifted;
              q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_div32x16_seq.sv
// Self-checking bench for div32x16_seq: directed cases plus randomized operands against an
// arithmetic reference model.
module tb_div32x16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_zero, overflow;
  logic [15:0] quotient, remainder;

  int unsigned errors = 0;
  int unsigned checks = 0;

  div32x16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division plus the saturation rules; latency counted in edges after
  // the accepting edge (WIDTH+1 normal, 1 for saturated cases).
  function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov, output int unsigned lat);
    logic [15:0] hi;
    hi = dd[31:16];
    dz = (dv == 16'd0);
    ov = !dz && (hi >= dv);
    if (dz || ov) begin
      q   = 16'hFFFF;
      r   = dd[15:0];
      lat = 1;
    end else begin
      q   = 16'(dd / {16'd0, dv});
      r   = 16'(dd % {16'd0, dv});
      lat = 17;
    end
  endfunction

  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, output int unsigned lat);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] dd, input logic [15:0] dv);
    logic [15:0] eq, er;
    logic        edz, eov;
    int unsigned elat, lat;
    model(dd, dv, eq, er, edz, eov, elat);
    run_op(dd, dv, lat);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_zero"}, div_zero, edz);
    chk({tag, "_overflow"}, overflow, eov);
    if (!edz && !eov) begin
      chk({tag, "_invariant"}, 32'(quotient) * 32'(dv) + 32'(remainder), dd);
      chk({tag, "_rem_lt_div"}, remainder < dv, 1);
    end
    step();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int unsigned lat;
    int unsigned ndone;
    logic [15:0] dv, hi;
    int unsigned mode;

    // Reset state
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {div_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1) basic divide, 2) multiplier inverse
    expect_op("t1", 32'd1000, 16'd7);
    expect_op("t2", 32'hFFFE_0001, 16'hFFFF);

    // start presented during DONE is ignored, then honoured from IDLE
    run_op(32'd1000, 16'd7, lat);
    chk("sd_lat1", lat, 17);
    chk("sd_q1", quotient, 142);
    dividend = 32'd5000;
    divisor  = 16'd3;
    start    = 1'b1;
    step();
    chk("sd_done_drop", done, 0);
    chk("sd_not_accepted", busy, 0);
    step();
    start = 1'b0;
    chk("sd_accepted", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk("sd_lat2", lat, 17);
    chk("sd_q2", quotient, 1666);
    chk("sd_r2", remainder, 2);
    step();

    // 3) divide by zero, 4) overflow
    expect_op("t3", 32'h0000_1234, 16'd0);
    expect_op("t4", 32'h0001_0000, 16'd1);

    // 5) stall mid-RUN plus start pulsed while busy
    dividend = 32'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    repeat (5) begin step(); lat++; end
    enable   = 1'b0;
    start    = 1'b1;
    dividend = 32'd99;
    divisor  = 16'd2;
    repeat (3) begin step(); lat++; end
    chk("t5_held_quotient", quotient, 16'hFFFF);
    chk("t5_busy_stalled", busy, 1);
    enable = 1'b1;
    repeat (2) begin step(); lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk("t5_latency", lat, 20);
    chk("t5_quotient", quotient, 142);
    chk("t5_remainder", remainder, 6);
    chk("t5_flags", {div_zero, overflow}, 0);
    ndone = 0;
    repeat (25) begin
      step();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("t5_not_queued", ndone, 0);

    // 6) asynchronous reset mid-RUN aborts
    dividend = 32'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_quotient", quotient, 0);
    chk("t6_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("t6_no_done", ndone, 0);

    // Randomized operands, mixing normal, divide-by-zero and overflow cases
    for (int unsigned i = 0; i < 1500; i++) begin
      mode = $urandom_range(0, 9);
      dv   = 16'($urandom);
      if (mode == 0) begin
        dv = 16'd0;
        hi = 16'($urandom);
      end else if (mode == 1) begin
        hi = 16'(32'(dv) + $urandom_range(0, 32'hFFFF - 32'(dv)));
      end else begin
        if (dv == 16'd0) dv = 16'd1;
        hi = 16'($urandom % 32'(dv));
      end
      expect_op("rnd", {hi, 16'($urandom)}, dv);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
